// File: rtl/branch_cmp_arbiter.sv
// Two-requester round-robin RISC-V branch comparator: IDLE -> CMP -> RESP handshake FSM.
// Define CMP_SIGNED_EN to support BLT/BGE; otherwise ops 100/101 report rsp_err.
module branch_cmp_arbiter #(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [2:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [2:0]   req1_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic         rsp_taken,
  output logic         rsp_lt,
  output logic         rsp_eq,
  output logic         rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           rr_last_q, rr_last_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]     op_q, op_d;
  logic           id_q, id_d;
  logic           rsp_id_q, rsp_id_d;
  logic           rsp_taken_q, rsp_taken_d;
  logic           rsp_lt_q, rsp_lt_d;
  logic           rsp_eq_q, rsp_eq_d;
  logic           rsp_err_q, rsp_err_d;

  logic any_valid, gnt_id;
  logic cmp_eq, cmp_ult, cmp_lt, op_legal, cmp_taken;

  // Contention goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    gnt_id    = (req0_valid & req1_valid) ? ~rr_last_q : req1_valid;
  end

  always_comb begin
    cmp_eq  = (a_q == b_q);
    cmp_ult = (a_q < b_q);
`ifdef CMP_SIGNED_EN
    cmp_lt   = (op_q[2:1] == 2'b10) ? ($signed(a_q) < $signed(b_q)) : cmp_ult;
    op_legal = (op_q[2:1] != 2'b01);
`else
    cmp_lt   = cmp_ult;
    op_legal = (op_q[2:1] == 2'b00) | (op_q[2:1] == 2'b11);
`endif
    cmp_taken = 1'b0;
    case (op_q)
      3'b000:         cmp_taken = cmp_eq;
      3'b001:         cmp_taken = ~cmp_eq;
      3'b100, 3'b110: cmp_taken = cmp_lt;
      3'b101, 3'b111: cmp_taken = ~cmp_lt;
      default:        cmp_taken = 1'b0;
    endcase
    cmp_taken = cmp_taken & op_legal;
  end

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    id_d        = id_q;
    rsp_id_d    = rsp_id_q;
    rsp_taken_d = rsp_taken_q;
    rsp_lt_d    = rsp_lt_q;
    rsp_eq_d    = rsp_eq_q;
    rsp_err_d   = rsp_err_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          // Gated by rst_n so neither ready can rise while reset is held.
          req0_ready = rst_n & ~gnt_id;
          req1_ready = rst_n & gnt_id;
          a_d        = gnt_id ? req1_a  : req0_a;
          b_d        = gnt_id ? req1_b  : req0_b;
          op_d       = gnt_id ? req1_op : req0_op;
          id_d       = gnt_id;
          rr_last_d  = gnt_id;
          state_d    = CMP;
        end
      end
      CMP: begin
        rsp_id_d    = id_q;
        rsp_taken_d = cmp_taken;
        rsp_lt_d    = cmp_lt;
        rsp_eq_d    = cmp_eq;
        rsp_err_d   = ~op_legal;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_last_q   <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      id_q        <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_taken_q <= 1'b0;
      rsp_lt_q    <= 1'b0;
      rsp_eq_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      id_q        <= id_d;
      rsp_id_q    <= rsp_id_d;
      rsp_taken_q <= rsp_taken_d;
      rsp_lt_q    <= rsp_lt_d;
      rsp_eq_q    <= rsp_eq_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_taken = rsp_taken_q;
  assign rsp_lt    = rsp_lt_q;
  assign rsp_eq    = rsp_eq_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_branch_cmp_arbiter.sv
// Directed bench for branch_cmp_arbiter: handshake timing, round-robin, op decode, reset abort.
module tb_branch_cmp_arbiter;
  localparam int unsigned N = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_op, req1_op;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_taken, rsp_lt, rsp_eq, rsp_err;

  int checks = 0;
  int errors = 0;

  branch_cmp_arbiter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_taken(rsp_taken), .rsp_lt(rsp_lt), .rsp_eq(rsp_eq), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic id, input logic tk,
                         input logic lt, input logic eq, input logic er);
    chk({tag, "_valid"}, 64'(rsp_valid), 64'(v));
    chk({tag, "_id"},    64'(rsp_id),    64'(id));
    chk({tag, "_taken"}, 64'(rsp_taken), 64'(tk));
    chk({tag, "_lt"},    64'(rsp_lt),    64'(lt));
    chk({tag, "_eq"},    64'(rsp_eq),    64'(eq));
    chk({tag, "_err"},   64'(rsp_err),   64'(er));
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk({tag, "_rdy0"}, 64'(req0_ready), 64'(r0));
    chk({tag, "_rdy1"}, 64'(req1_ready), 64'(r1));
  endtask

  logic [N-1:0] all_ones;
  logic         s_tk, s_lt, s_err;

  initial begin
    all_ones = '1;
`ifdef CMP_SIGNED_EN
    s_tk = 1'b1; s_lt = 1'b1; s_err = 1'b0;
`else
    s_tk = 1'b0; s_lt = 1'b0; s_err = 1'b1;
`endif
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_op = 3'b000;
    req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_op = 3'b000;
    #1;
    chk_rdy("reset", 1'b0, 1'b0);
    chk_rsp("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // BEQ 4==4 from requester 0, two-cycle latency
    req0_valid = 1'b1; req0_a = 64'd4; req0_b = 64'd4; req0_op = 3'b000;
    #1;
    chk_rdy("beq_accept", 1'b1, 1'b0);
    cyc();
    req0_valid = 1'b0;
    chk("beq_cmp_valid", 64'(rsp_valid), 64'd0);
    chk_rdy("beq_cmp", 1'b0, 1'b0);
    cyc();
    chk_rsp("beq", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk("beq_idle_valid", 64'(rsp_valid), 64'd0);
    chk("beq_hold_eq", 64'(rsp_eq), 64'd1);

    // Fresh reset, then contention: req0 wins first, req1 second
    rst_n = 1'b0; #1; rst_n = 1'b1;
    cyc();
    req0_valid = 1'b1; req0_a = 64'd2;  req0_b = 64'd4;  req0_op = 3'b110;
    req1_valid = 1'b1; req1_a = 64'd64; req1_b = 64'd32; req1_op = 3'b111;
    #1;
    chk_rdy("rr0_accept", 1'b1, 1'b0);
    cyc();
    req0_valid = 1'b0;
    chk_rdy("rr0_cmp", 1'b0, 1'b0);
    cyc();
    chk_rsp("rr0", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_rdy("rr0_resp", 1'b0, 1'b0);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk_rdy("rr1_accept", 1'b0, 1'b1);
    cyc();
    req1_valid = 1'b0;
    cyc();
    chk_rsp("rr1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;

    // Contention again: last grant was 1 so req0 wins; operand change in flight ignored
    req0_valid = 1'b1; req0_a = all_ones; req0_b = 64'd1; req0_op = 3'b100;
    req1_valid = 1'b1; req1_a = 64'd5;    req1_b = 64'd5; req1_op = 3'b010;
    #1;
    chk_rdy("blt_accept", 1'b1, 1'b0);
    cyc();
    req0_a = '0; req0_op = 3'b000;
    cyc();
    chk_rsp("blt", 1'b1, 1'b0, s_tk, s_lt, 1'b0, s_err);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk_rdy("illegal_accept", 1'b0, 1'b1);
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();
    chk_rsp("illegal", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;

    // BNE with consumer stalling 5 cycles; requesters keep asking
    req0_valid = 1'b1; req0_a = 64'd32; req0_b = 64'd8; req0_op = 3'b001;
    #1;
    chk_rdy("bne_accept", 1'b1, 1'b0);
    cyc();
    req1_valid = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d_valid", i), 64'(rsp_valid), 64'd1);
      chk($sformatf("stall%0d_taken", i), 64'(rsp_taken), 64'd1);
      chk_rdy($sformatf("stall%0d", i), 1'b0, 1'b0);
      cyc();
    end
    chk_rsp("bne", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;

    // Reset pulse in CMP aborts the operation
    req0_valid = 1'b1; req0_a = 64'd7; req0_b = 64'd7; req0_op = 3'b000;
    cyc();
    chk("abort_cmp_valid", 64'(rsp_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    chk_rsp("abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_rdy("abort", 1'b0, 1'b0);
    req0_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("abort_quiet%0d", i), 64'(rsp_valid), 64'd0);
    end

    // Operation resumes after reset: BNE 3,3 from requester 1
    req1_valid = 1'b1; req1_a = 64'd3; req1_b = 64'd3; req1_op = 3'b001;
    #1;
    chk_rdy("resume_accept", 1'b0, 1'b1);
    cyc();
    req1_valid = 1'b0;
    cyc();
    chk_rsp("resume", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk("resume_idle", 64'(rsp_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_cmp_arbiter.md
BRANCH_CMP_ARBITER -- requirements
Module: branch_cmp_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 64, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req0_valid, input, 1 bit: requester 0 presents an operation.
REQ-005 The block SHALL have port req0_ready, output, 1 bit: requester 0 operation accepted this cycle.
REQ-006 The block SHALL have ports req0_a and req0_b, input, N bits each: requester 0 operands.
REQ-007 The block SHALL have port req0_op, input, 3 bits: requester 0 RISC-V branch funct3.
REQ-008 The block SHALL have ports req1_valid, req1_ready, req1_a, req1_b and req1_op, identical to the requester 0 ports, for requester 1.
REQ-009 The block SHALL have port rsp_valid, output, 1 bit: a result is held on the response channel.
REQ-010 The block SHALL have port rsp_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port rsp_id, output, 1 bit: index of the requester that owns the result.
REQ-012 The block SHALL have ports rsp_taken, rsp_lt, rsp_eq and rsp_err, output, 1 bit each: branch decision, less-than flag, equality flag, and illegal-op flag.

Function
REQ-013 The block SHALL implement a three-state FSM IDLE -> CMP -> RESP -> IDLE.
REQ-014 In IDLE, when at least one reqX_valid is 1, the block SHALL grant one requester, assert that requester's reqX_ready combinationally in the same cycle, latch its a, b, op and id, and go to CMP.
REQ-015 reqX_ready SHALL be 0 in CMP and RESP, and 0 for the requester that is not granted.
REQ-016 When both requesters are valid, the grant SHALL go to the requester not served by the most recent grant (round-robin); a lone valid requester SHALL always win.
REQ-017 In CMP the block SHALL compare the latched operands, register rsp_lt, rsp_eq, rsp_taken and rsp_err, and go to RESP.
REQ-018 In RESP, rsp_valid SHALL be 1 with all rsp_* outputs stable until the cycle in which rsp_ready is 1, after which the FSM SHALL return to IDLE.
REQ-019 Latency SHALL be fixed: acceptance in cycle T gives rsp_valid=1 in cycle T+2. Peak throughput SHALL be one operation per 3 cycles.
REQ-020 op decoding SHALL be: 000 BEQ (eq), 001 BNE (!eq), 100 BLT (lt signed), 101 BGE (!lt signed), 110 BLTU (lt unsigned), 111 BGEU (!lt unsigned).
REQ-021 op 010 or 011 SHALL give rsp_err=1 and rsp_taken=0; rsp_lt and rsp_eq SHALL still report the unsigned comparison.
REQ-022 rsp_eq SHALL be 1 if and only if a==b over all N bits. rsp_lt SHALL use signed two's-complement ordering for ops 100 and 101 and unsigned ordering otherwise.
REQ-023 rsp_valid SHALL be 0 in IDLE and CMP. rsp_* data outputs SHALL hold their last registered values outside RESP.
REQ-024 A change in reqX_valid or operands while not in IDLE SHALL have no effect on the operation in flight.

Reset
REQ-025 When rst_n=0, the block SHALL immediately force: FSM to IDLE, rsp_valid=0, rsp_id=0, rsp_taken=0, rsp_lt=0, rsp_eq=0, rsp_err=0, and req0_ready=req1_ready=0.
REQ-026 Reset SHALL set the round-robin state so that requester 0 wins the first contended grant.
REQ-027 Reset asserted mid-operation (CMP or RESP) SHALL discard the operation with no response produced. Operation SHALL resume on the first rising edge after rst_n returns to 1.

Configuration
REQ-028 The macro CMP_SIGNED_EN SHALL control signed comparison support.
REQ-029 With CMP_SIGNED_EN defined, ops 100 and 101 SHALL behave as in REQ-020.
REQ-030 With CMP_SIGNED_EN undefined, ops 100 and 101 SHALL be treated as illegal per REQ-021 (rsp_err=1, rsp_taken=0), and no signed comparison logic SHALL be synthesized.

Verification
REQ-031 The bench SHALL cover: req0 only, a=4, b=4, op=000 -> after 2 cycles rsp_valid=1, id=0, taken=1, eq=1, lt=0, err=0.
REQ-032 The bench SHALL cover: both requesters valid after reset, req0 a=2, b=4, op=110 and req1 a=64, b=32, op=111 -> first response id=0, taken=1; second response id=1, taken=1.
REQ-033 The bench SHALL cover: a=0xFF..FF (-1), b=1, op=100 -> taken=1 and lt=1 with CMP_SIGNED_EN defined; err=1 and taken=0 with CMP_SIGNED_EN undefined.
REQ-034 The bench SHALL cover: rsp_ready held at 0 for 5 cycles during RESP with op=001, a=32, b=8 -> rsp_valid and taken=1 stable for 5 cycles, both reqX_ready=0 throughout.
REQ-035 The bench SHALL cover: op=010 -> err=1, taken=0.
REQ-036 The bench SHALL cover: rst_n pulsed low while in CMP -> no response produced, and all outputs read 0 immediately.
